bcd_mod_counter: RTL and testbench
==================================

BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter MIN_VAL, default 0: lowest count value; 1 for 12-hour/day/month use.
REQ-002 Parameter MAX_VAL, default 23: highest count value; MAX_VAL > MIN_VAL, MAX_VAL <= 99.
REQ-003 Parameter DIGITS, default 2: number of BCD digits on count_num; 4*DIGITS bits wide.
REQ-004 Derived localparam BW = 7: binary width, sufficient for 0..99.
REQ-005 clk  input  1: single clock for the whole block; all state changes on its rising edge.
REQ-006 RESET  input  1: reset, synchronous, active-low.
REQ-007 en  input  1: count tick, one-cycle qualifier from the upstream prescaler or carry chain.
REQ-008 up  input  1: direction; 1 = increment, 0 = decrement.
REQ-009 adj  input  1: manual-set pulse from a debounced key; steps the count once in the `up` direction.
REQ-010 load  input  1: synchronous load strobe.
REQ-011 load_val  input  BW: binary value to load.
REQ-012 count_num  output  4*DIGITS: registered count, BCD, least significant digit in bits [3:0].
REQ-013 bin_val  output  BW: registered count, binary.
REQ-014 ToCarry  output  1: one-cycle pulse on an up-wrap from MAX_VAL to MIN_VAL.
REQ-015 ToBorrow  output  1: one-cycle pulse on a down-wrap from MIN_VAL to MAX_VAL.

Function
REQ-016 Per-edge priority SHALL be: RESET, then load, then adj, then en, otherwise hold.
REQ-017 load: if MIN_VAL <= load_val <= MAX_VAL, the count SHALL become load_val; otherwise it SHALL become MIN_VAL.
REQ-018 en with up=1: the count SHALL go to count+1, or to MIN_VAL when count == MAX_VAL.
REQ-019 en with up=0: the count SHALL go to count-1, or to MAX_VAL when count == MIN_VAL.
REQ-020 adj SHALL step and wrap exactly as en does, but SHALL NOT assert ToCarry or ToBorrow.
REQ-021 ToCarry SHALL be registered and SHALL be high for exactly the one cycle in which count_num first shows MIN_VAL after an en up-wrap; it is low at all other times.
REQ-022 ToBorrow SHALL be registered and SHALL be high for exactly the one cycle in which count_num first shows MAX_VAL after an en down-wrap; it is low at all other times.
REQ-023 A cycle with load or adj asserted SHALL clear ToCarry and ToBorrow, even when en is also high in that cycle.
REQ-024 Latency from a qualifying input edge to count_num, bin_val, ToCarry and ToBorrow SHALL be exactly one clock; there is no combinational path from any input to any output.
REQ-025 count_num SHALL be the BCD encoding of bin_val in the same cycle; digits above the value SHALL read 0.
REQ-026 If the internal count is ever outside MIN_VAL..MAX_VAL, the next en or adj SHALL force it to MIN_VAL with no pulse.
REQ-027 en held high continuously SHALL advance the count once per clock; back-to-back wraps SHALL produce back-to-back pulses.

Reset
REQ-028 While RESET = 0 at a rising edge of clk: count SHALL become MIN_VAL, count_num its BCD value, and ToCarry = ToBorrow = 0.
REQ-029 Reset SHALL override load, adj and en in the same cycle, including mid-sequence; no pulse SHALL be emitted on the first edge after release.

Structure
REQ-030 Shared package watch_cnt_pkg SHALL hold: the BCD digit width constant (4), the maximum supported value constant (99), and the default MIN_VAL/MAX_VAL pairs (seconds/minutes 0..59, hours 0..23 and 1..12, day 1..31).
REQ-031 One sub-module, bin2bcd (combinational, parametrised by BW and DIGITS), SHALL feed the count_num register.
REQ-032 The block SHALL be cascadable: ToCarry of one instance drives en of the next instance with up=1.

Verification
REQ-033 Default parameters, RESET low for 2 clocks then high, en=1, up=1 for 25 clocks -> count_num 0x00..0x23, then 0x00 with ToCarry high for that single cycle.
REQ-034 MIN_VAL=1, MAX_VAL=12, count at 1, en=1, up=0 -> count_num 0x12, ToBorrow pulses once; the next tick gives 0x11 with ToBorrow low.
REQ-035 Count at 23, adj=1 and en=1 in the same cycle -> count_num 0x00, ToCarry stays 0.
REQ-036 load=1 with load_val=30 (default params) -> count_num 0x00; load_val=17 -> count_num 0x17, bin_val 17; both one clock after the load edge.
REQ-037 RESET low while en=1 and the count is at 22 -> count_num 0x00 and no ToCarry pulse either during reset or after release.
REQ-038 Two cascaded instances (0..59 feeding 0..23), en held high for 1440 clocks -> upper instance wraps exactly once, and its ToCarry pulses once.

Source files
------------

// File: rtl/watch_cnt_pkg.sv
// Shared constants, operation encoding and range helper for the watch counter family.
package watch_cnt_pkg;

    localparam int unsigned BCD_W         = 4;
    localparam int unsigned MAX_SUPPORTED = 99;
    localparam int unsigned CNT_BW        = 7;

    localparam int unsigned MS_MIN   = 0;
    localparam int unsigned MS_MAX   = 59;
    localparam int unsigned HR24_MIN = 0;
    localparam int unsigned HR24_MAX = 23;
    localparam int unsigned HR12_MIN = 1;
    localparam int unsigned HR12_MAX = 12;
    localparam int unsigned DAY_MIN  = 1;
    localparam int unsigned DAY_MAX  = 31;

    typedef enum logic [1:0] {OpHold, OpLoad, OpAdj, OpTick} cnt_op_e;

    // lo <= v <= hi, written so a zero lower bound does not fold to a constant compare
    function automatic logic in_window(input logic [CNT_BW-1:0] v,
                                       input logic [CNT_BW-1:0] lo,
                                       input logic [CNT_BW-1:0] hi);
        return (({1'b0, v} + 8'd1) > {1'b0, lo}) && (v <= hi);
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational binary to packed-BCD converter, least significant digit in the low nibble.
module bin2bcd
    import watch_cnt_pkg::*;
#(
    parameter int unsigned BW     = CNT_BW,
    parameter int unsigned DIGITS = 2
) (
    input  logic [BW-1:0]           bin,
    output logic [BCD_W*DIGITS-1:0] bcd
);

    logic [BW-1:0] rem;

    always_comb begin
        bcd = '0;
        rem = bin;
        for (int i = 0; i < int'(DIGITS); i++) begin
            bcd[BCD_W*i +: BCD_W] = BCD_W'(rem % BW'(10));
            rem                   = rem / BW'(10);
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Cascadable modulo counter (MIN_VAL..MAX_VAL) with registered binary and BCD views,
// plus wrap pulses that only en-driven steps can raise.
module bcd_mod_counter
    import watch_cnt_pkg::*;
#(
    parameter int unsigned MIN_VAL = HR24_MIN,
    parameter int unsigned MAX_VAL = HR24_MAX,
    parameter int unsigned DIGITS  = 2,
    localparam int unsigned BW     = CNT_BW
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic                en,
    input  logic                up,
    input  logic                adj,
    input  logic                load,
    input  logic [BW-1:0]       load_val,
    output logic [4*DIGITS-1:0] count_num,
    output logic [BW-1:0]       bin_val,
    output logic                ToCarry,
    output logic                ToBorrow
);

    localparam logic [BW-1:0] MIN_B = BW'(MIN_VAL);
    localparam logic [BW-1:0] MAX_B = BW'((MAX_VAL > MAX_SUPPORTED) ? MAX_SUPPORTED : MAX_VAL);

    logic [BW-1:0]       count_q, count_d, bcd_src;
    logic [4*DIGITS-1:0] count_num_q, bcd_next;
    logic                carry_q, carry_d, borrow_q, borrow_d;
    logic                in_range, at_min, at_max;
    cnt_op_e             op;

    always_comb begin
        if (load) begin
            op = OpLoad;
        end else if (adj) begin
            op = OpAdj;
        end else if (en) begin
            op = OpTick;
        end else begin
            op = OpHold;
        end
    end

    assign in_range = in_window(count_q, MIN_B, MAX_B);
    assign at_min   = (count_q == MIN_B);
    assign at_max   = (count_q == MAX_B);

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        unique case (op)
            OpHold: ;
            OpLoad: count_d = in_window(load_val, MIN_B, MAX_B) ? load_val : MIN_B;
            OpAdj, OpTick: begin
                // A corrupted count recovers to MIN_VAL silently.
                if (!in_range) begin
                    count_d = MIN_B;
                end else if (up) begin
                    count_d = at_max ? MIN_B : count_q + BW'(1);
                    carry_d = at_max && (op == OpTick);
                end else begin
                    count_d  = at_min ? MAX_B : count_q - BW'(1);
                    borrow_d = at_min && (op == OpTick);
                end
            end
            default: ;
        endcase
    end

    // The BCD register is loaded from the converted next count, so both views stay aligned.
    assign bcd_src = RESET ? count_d : MIN_B;

    bin2bcd #(
        .BW     (BW),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .bin (bcd_src),
        .bcd (bcd_next)
    );

    always_ff @(posedge clk) begin
        if (!RESET) begin
            count_q     <= MIN_B;
            count_num_q <= bcd_next;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
        end else begin
            count_q     <= count_d;
            count_num_q <= bcd_next;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
        end
    end

    assign count_num = count_num_q;
    assign bin_val   = count_q;
    assign ToCarry   = carry_q;
    assign ToBorrow  = borrow_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench: modular-arithmetic model for a 0..23 and a 1..12 instance,
// directed vectors with literal expectations, and a 0..59 -> 0..23 cascade run.
module tb_bcd_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RESET, en, up, adj, load;
    logic [6:0] load_val;

    logic [7:0] num_a, num_b;
    logic [6:0] bin_a, bin_b;
    logic       car_a, bor_a, car_b, bor_b;

    logic       casc_rst, casc_en;
    logic [7:0] sec_num, hr_num;
    logic [6:0] sec_bin, hr_bin;
    logic       sec_car, sec_bor, hr_car, hr_bor;

    int vectors     = 0;
    int miscompares = 0;

    bcd_mod_counter u_a (
        .clk(clk), .RESET(RESET), .en(en), .up(up), .adj(adj), .load(load),
        .load_val(load_val), .count_num(num_a), .bin_val(bin_a),
        .ToCarry(car_a), .ToBorrow(bor_a)
    );

    bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_b (
        .clk(clk), .RESET(RESET), .en(en), .up(up), .adj(adj), .load(load),
        .load_val(load_val), .count_num(num_b), .bin_val(bin_b),
        .ToCarry(car_b), .ToBorrow(bor_b)
    );

    bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_sec (
        .clk(clk), .RESET(casc_rst), .en(casc_en), .up(1'b1), .adj(1'b0), .load(1'b0),
        .load_val(7'd0), .count_num(sec_num), .bin_val(sec_bin),
        .ToCarry(sec_car), .ToBorrow(sec_bor)
    );

    bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(23)) u_hr (
        .clk(clk), .RESET(casc_rst), .en(sec_car), .up(1'b1), .adj(1'b0), .load(1'b0),
        .load_val(7'd0), .count_num(hr_num), .bin_val(hr_bin),
        .ToCarry(hr_car), .ToBorrow(hr_bor)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bcd2(input int v);
        return 32'((v / 10) * 16 + (v % 10));
    endfunction

    // Model: count as an offset into a ring of size hi-lo+1.
    int  lo [2] = '{0, 1};
    int  hi [2] = '{23, 12};
    int  m_cnt [2];
    bit  m_car [2];
    bit  m_bor [2];
    bit  m_valid = 1'b0;
    int  m_span;
    bit  m_wrap;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_span = hi[i] - lo[i] + 1;
            m_car[i] = 1'b0;
            m_bor[i] = 1'b0;
            if (!RESET) begin
                m_cnt[i] = lo[i];
            end else if (load) begin
                m_cnt[i] = (int'(load_val) >= lo[i] && int'(load_val) <= hi[i]) ?
                           int'(load_val) : lo[i];
            end else if (adj || en) begin
                if (m_cnt[i] < lo[i] || m_cnt[i] > hi[i]) begin
                    m_cnt[i] = lo[i];
                end else begin
                    m_wrap   = up ? (m_cnt[i] == hi[i]) : (m_cnt[i] == lo[i]);
                    m_cnt[i] = lo[i] + ((m_cnt[i] - lo[i] + (up ? 1 : m_span - 1)) % m_span);
                    m_car[i] = !adj && up && m_wrap;
                    m_bor[i] = !adj && !up && m_wrap;
                end
            end
        end
        if (!RESET) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("a_num", 32'(num_a), bcd2(m_cnt[0]));
            chk("a_bin", 32'(bin_a), 32'(m_cnt[0]));
            chk("a_carry", 32'(car_a), 32'(m_car[0]));
            chk("a_borrow", 32'(bor_a), 32'(m_bor[0]));
            chk("b_num", 32'(num_b), bcd2(m_cnt[1]));
            chk("b_bin", 32'(bin_b), 32'(m_cnt[1]));
            chk("b_carry", 32'(car_b), 32'(m_car[1]));
            chk("b_borrow", 32'(bor_b), 32'(m_bor[1]));
        end
    end

    task automatic tick(input bit rst, input bit e, input bit u, input bit a, input bit l,
                        input int lv);
        RESET    = rst;
        en       = e;
        up       = u;
        adj      = a;
        load     = l;
        load_val = 7'(lv);
        @(posedge clk);
        #1;
    endtask

    int sec_pulses, hr_pulses, hr_wraps;
    logic [7:0] hr_prev;

    initial begin
        RESET = 1'b0; en = 1'b1; up = 1'b1; adj = 1'b0; load = 1'b0; load_val = '0;
        casc_rst = 1'b0; casc_en = 1'b0;

        // Reset overrides a pending tick.
        tick(0, 1, 1, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 0);
        chk("rst_a_num", 32'(num_a), 32'h00);
        chk("rst_a_carry", 32'(car_a), 32'h0);
        chk("rst_b_num", 32'(num_b), 32'h01);

        for (int k = 1; k <= 25; k++) begin
            tick(1, 1, 1, 0, 0, 0);
            if (k == 23) chk("up23_num", 32'(num_a), 32'h23);
            if (k == 24) begin
                chk("wrap_num", 32'(num_a), 32'h00);
                chk("wrap_carry", 32'(car_a), 32'h1);
            end
            if (k == 25) begin
                chk("post_wrap_num", 32'(num_a), 32'h01);
                chk("post_wrap_carry", 32'(car_a), 32'h0);
            end
        end

        // Down-wrap on the 1..12 instance.
        tick(1, 0, 1, 0, 1, 1);
        tick(1, 1, 0, 0, 0, 0);
        chk("b_down_num", 32'(num_b), 32'h12);
        chk("b_down_borrow", 32'(bor_b), 32'h1);
        tick(1, 1, 0, 0, 0, 0);
        chk("b_down2_num", 32'(num_b), 32'h11);
        chk("b_down2_borrow", 32'(bor_b), 32'h0);
        chk("a_down_num", 32'(num_a), 32'h23);
        chk("a_down_borrow", 32'(bor_a), 32'h1);

        // adj beats en and never pulses.
        tick(1, 0, 1, 0, 1, 23);
        tick(1, 1, 1, 1, 0, 0);
        chk("adj_wrap_num", 32'(num_a), 32'h00);
        chk("adj_wrap_carry", 32'(car_a), 32'h0);

        // Load range handling.
        tick(1, 0, 1, 0, 1, 30);
        chk("load30_num", 32'(num_a), 32'h00);
        tick(1, 0, 1, 0, 1, 17);
        chk("load17_num", 32'(num_a), 32'h17);
        chk("load17_bin", 32'(bin_a), 32'd17);
        chk("load17_b_num", 32'(num_b), 32'h01);

        // Reset mid-count with en high, then release.
        tick(1, 0, 1, 0, 1, 22);
        tick(0, 1, 1, 0, 0, 0);
        chk("rst_mid_num", 32'(num_a), 32'h00);
        chk("rst_mid_carry", 32'(car_a), 32'h0);
        tick(1, 1, 1, 0, 0, 0);
        chk("rst_rel_num", 32'(num_a), 32'h01);
        chk("rst_rel_carry", 32'(car_a), 32'h0);

        // load together with en suppresses the pulse.
        tick(1, 0, 1, 0, 1, 23);
        tick(1, 1, 1, 0, 0, 0);
        chk("carry_again", 32'(car_a), 32'h1);
        tick(1, 1, 1, 0, 1, 5);
        chk("load_en_num", 32'(num_a), 32'h05);
        chk("load_en_carry", 32'(car_a), 32'h0);

        // adj down from MIN_VAL wraps without a borrow.
        tick(1, 0, 1, 0, 1, 0);
        tick(1, 0, 0, 1, 0, 0);
        chk("adj_down_num", 32'(num_a), 32'h23);
        chk("adj_down_borrow", 32'(bor_a), 32'h0);
        tick(1, 0, 0, 0, 0, 9);
        chk("hold_num", 32'(num_a), 32'h23);

        // Mixed directed vectors, checked by the model every cycle.
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 0, 1, 1, 0, 0);
        tick(1, 1, 1, 0, 1, 12);
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0);
        tick(1, 0, 0, 1, 0, 0);
        tick(1, 1, 0, 0, 1, 99);
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0);

        // Cascade: 0..59 feeding 0..23 for 1440 ticks.
        chk("casc_rst_num", 32'(hr_num), 32'h00);
        casc_rst = 1'b1;
        sec_pulses = 0; hr_pulses = 0; hr_wraps = 0;
        hr_prev = hr_num;
        casc_en = 1'b1;
        for (int k = 0; k < 1443; k++) begin
            if (k == 1440) casc_en = 1'b0;
            @(posedge clk);
            #1;
            if (sec_car) sec_pulses++;
            if (hr_car) hr_pulses++;
            if (hr_prev == 8'h23 && hr_num == 8'h00) hr_wraps++;
            hr_prev = hr_num;
        end
        chk("casc_sec_pulses", 32'(sec_pulses), 32'd24);
        chk("casc_hr_pulses", 32'(hr_pulses), 32'd1);
        chk("casc_hr_wraps", 32'(hr_wraps), 32'd1);
        chk("casc_hr_num", 32'(hr_num), 32'h00);
        chk("casc_sec_num", 32'(sec_num), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
